// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter: shares one SDRAM controller command port between the
// recording writer (W) and the playback reader (R). Grants alternate on a tie,
// only one command is outstanding at a time, and every output is registered.
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to abort a command that has not
// completed within TIMEOUT_CYCLES and raise the sticky timeout_err flag.
module sdram_request_arbiter #(
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clock_50Mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] sdram_inputAddress,
  output logic [DATA_W-1:0] sdram_writeData,
  output logic              sdram_isWriting,
  output logic              sdram_inputValid,
  input  logic [DATA_W-1:0] sdram_readData,
  input  logic              sdram_outputValid,
  input  logic              sdram_recievedCommand,
  input  logic              sdram_isBusy,
  output logic              arb_busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e stateQ, stateD;

  // lastGrantWQ = 1 when the writer held the most recent grant
  logic lastGrantWQ, lastGrantWD;
  logic grantAny, pickW, timeoutHit;

  logic [ADDR_W-1:0] addrD;
  logic [DATA_W-1:0] wdataD, rdataD;
  logic              isWritingD, inputValidD, wrAckD, rdAckD;

  assign grantAny = enable & ~sdram_isBusy & (wr_req | rd_req);
  // On a tie, the requester that did not win last time goes next
  assign pickW    = wr_req & (~rd_req | ~lastGrantWQ);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] toCntQ;
  logic            toErrQ;

  assign timeoutHit  = (stateQ != StIdle) && (toCntQ == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = toErrQ;

  // Cycle counter for the command in flight; held at zero while idle
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      toCntQ <= '0;
      toErrQ <= 1'b0;
    end else begin
      if (stateQ == StIdle || timeoutHit) begin
        toCntQ <= '0;
      end else begin
        toCntQ <= toCntQ + 1'b1;
      end
      if (timeoutHit) begin
        toErrQ <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (grantAny) stateD = StIssue;
      end
      StIssue: begin
        if (sdram_recievedCommand) stateD = sdram_isWriting ? StIdle : StWaitRd;
      end
      StWaitRd: begin
        if (sdram_outputValid) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    if (timeoutHit) stateD = StIdle;
  end

  // Next values of the registered outputs
  always_comb begin
    addrD       = sdram_inputAddress;
    wdataD      = sdram_writeData;
    isWritingD  = sdram_isWriting;
    inputValidD = sdram_inputValid;
    rdataD      = rd_data;
    lastGrantWD = lastGrantWQ;
    wrAckD      = 1'b0;
    rdAckD      = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (grantAny) begin
          addrD       = pickW ? wr_addr : rd_addr;
          wdataD      = pickW ? wr_data : sdram_writeData;
          isWritingD  = pickW;
          inputValidD = 1'b1;
          lastGrantWD = pickW;
        end
      end
      StIssue: begin
        if (sdram_recievedCommand) begin
          inputValidD = 1'b0;
          wrAckD      = sdram_isWriting;
        end
      end
      StWaitRd: begin
        if (sdram_outputValid) begin
          rdataD = sdram_readData;
          rdAckD = 1'b1;
        end
      end
      default: ;
    endcase
    // An aborted command never acknowledges and never updates rd_data
    if (timeoutHit) begin
      inputValidD = 1'b0;
      wrAckD      = 1'b0;
      rdAckD      = 1'b0;
      rdataD      = rd_data;
    end
  end

  // Output and grant-history registers
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
      sdram_isWriting    <= 1'b0;
      sdram_inputValid   <= 1'b0;
      rd_data            <= '0;
      wr_ack             <= 1'b0;
      rd_ack             <= 1'b0;
      arb_busy           <= 1'b0;
      lastGrantWQ        <= 1'b0;
    end else begin
      sdram_inputAddress <= addrD;
      sdram_writeData    <= wdataD;
      sdram_isWriting    <= isWritingD;
      sdram_inputValid   <= inputValidD;
      rd_data            <= rdataD;
      wr_ack             <= wrAckD;
      rd_ack             <= rdAckD;
      arb_busy           <= (stateD != StIdle);
      lastGrantWQ        <= lastGrantWD;
    end
  end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Bench for sdram_request_arbiter: a table of single transactions, then hand
// sequences for contention, busy/enable gating, reset mid-read and (with
// SDRAM_ARB_TIMEOUT_EN) the timeout abort. A monitor pops expected commands and
// acks from scoreboard queues as the DUT produces them.
module tb_sdram_request_arbiter;

  logic        clock_50Mhz = 1'b0;
  logic        reset, enable;
  logic        wr_req, rd_req;
  logic [24:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        wr_ack, rd_ack;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_writeData, sdram_readData;
  logic        sdram_isWriting, sdram_inputValid;
  logic        sdram_outputValid, sdram_recievedCommand, sdram_isBusy;
  logic        arb_busy, timeout_err;

  always #10 clock_50Mhz = ~clock_50Mhz;

  sdram_request_arbiter #(
    .ADDR_W         (25),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock_50Mhz           (clock_50Mhz),
    .reset                 (reset),
    .enable                (enable),
    .wr_req                (wr_req),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wr_ack                (wr_ack),
    .rd_req                (rd_req),
    .rd_addr               (rd_addr),
    .rd_data               (rd_data),
    .rd_ack                (rd_ack),
    .sdram_inputAddress    (sdram_inputAddress),
    .sdram_writeData       (sdram_writeData),
    .sdram_isWriting       (sdram_isWriting),
    .sdram_inputValid      (sdram_inputValid),
    .sdram_readData        (sdram_readData),
    .sdram_outputValid     (sdram_outputValid),
    .sdram_recievedCommand (sdram_recievedCommand),
    .sdram_isBusy          (sdram_isBusy),
    .arb_busy              (arb_busy),
    .timeout_err           (timeout_err)
  );

  typedef struct {
    bit          isW;
    logic [24:0] addr;
    logic [15:0] data;
    int          width;  // cycles sdram_inputValid must stay high
  } cmd_t;

  typedef struct {
    bit          isW;
    logic [15:0] rdata;
  } ack_t;

  typedef struct {
    bit          isW;
    logic [24:0] addr;
    logic [15:0] data;
    int          recvDly;
    int          rdLat;
    logic [15:0] rdVal;
    int          expWidth;
  } vec_t;

  cmd_t cmdQ[$];
  ack_t ackQ[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushCmd(input bit isW, input logic [24:0] a, input logic [15:0] d, input int w);
    cmd_t c;
    c.isW = isW; c.addr = a; c.data = d; c.width = w;
    cmdQ.push_back(c);
  endtask

  task automatic pushAck(input bit isW, input logic [15:0] d);
    ack_t k;
    k.isW = isW; k.rdata = d;
    ackQ.push_back(k);
  endtask

  task automatic waitAck(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock_50Mhz);
      if (wr_ack || rd_ack) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_inputValid"}, 32'(sdram_inputValid), 0);
    chk({tag, "_isWriting"}, 32'(sdram_isWriting), 0);
    chk({tag, "_addr"}, 32'(sdram_inputAddress), 0);
    chk({tag, "_wdata"}, 32'(sdram_writeData), 0);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    chk({tag, "_rd_ack"}, 32'(rd_ack), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // SDRAM controller model
  bit          ctrlOn = 1'b1;
  int          recvDelay = 0;
  int          rdLat = 1;
  logic [15:0] rdDataVal = 16'h0;
  int          vcnt = 0;
  bit          pendingRd = 1'b0;
  int          rdCnt = 0;

  always @(negedge clock_50Mhz) begin
    sdram_outputValid = 1'b0;
    sdram_readData    = 16'hDEAD;
    if (pendingRd) begin
      if (rdCnt <= 1) begin
        sdram_outputValid = 1'b1;
        sdram_readData    = rdDataVal;
        pendingRd         = 1'b0;
      end else begin
        rdCnt--;
      end
    end
    if (sdram_inputValid && ctrlOn) begin
      if (vcnt == recvDelay) begin
        sdram_recievedCommand = 1'b1;
        if (!sdram_isWriting) begin
          pendingRd = 1'b1;
          rdCnt     = rdLat;
        end
      end else begin
        sdram_recievedCommand = 1'b0;
      end
      vcnt++;
    end else begin
      sdram_recievedCommand = 1'b0;
      vcnt = 0;
    end
  end

  // Monitor: scoreboard pops, hold checks, pulse-width and exclusivity checks
  bit          prevValid = 1'b0;
  bit          prevErr = 1'b0;
  int          width = 0;
  int          outstanding = 0;
  cmd_t        cur;
  logic [24:0] holdAddr;
  logic [15:0] holdData;
  bit          holdW;

  always @(negedge clock_50Mhz) begin
    if (reset) begin
      prevValid   = 1'b0;
      prevErr     = 1'b0;
      width       = 0;
      outstanding = 0;
    end else begin
      if (timeout_err && !prevErr) outstanding = 0;
      if (sdram_inputValid && !prevValid) begin
        chk("one_outstanding", 32'(outstanding), 0);
        outstanding = 1;
        width = 0;
        holdAddr = sdram_inputAddress;
        holdData = sdram_writeData;
        holdW    = sdram_isWriting;
        if (cmdQ.size() == 0) begin
          chk("cmd_unexpected", 32'(cmdQ.size()), 1);
          cur.width = -1;
        end else begin
          cur = cmdQ.pop_front();
          chk("cmd_isWriting", 32'(sdram_isWriting), 32'(cur.isW));
          chk("cmd_addr", 32'(sdram_inputAddress), 32'(cur.addr));
          if (cur.isW) chk("cmd_wdata", 32'(sdram_writeData), 32'(cur.data));
        end
      end
      if (sdram_inputValid) begin
        width++;
        chk("busy_during_cmd", 32'(arb_busy), 1);
        if (prevValid) begin
          chk("hold_addr", 32'(sdram_inputAddress), 32'(holdAddr));
          chk("hold_wdata", 32'(sdram_writeData), 32'(holdData));
          chk("hold_isWriting", 32'(sdram_isWriting), 32'(holdW));
        end
      end
      if (!sdram_inputValid && prevValid && cur.width >= 0) begin
        chk("valid_width", 32'(width), 32'(cur.width));
      end
      if (wr_ack && rd_ack) chk("acks_exclusive", 32'({wr_ack, rd_ack}), 0);
      if (wr_ack || rd_ack) begin
        outstanding = 0;
        chk("busy_falls_with_ack", 32'(arb_busy), 0);
        if (ackQ.size() == 0) begin
          chk("ack_unexpected", 32'({wr_ack, rd_ack}), 0);
        end else begin
          ack_t k;
          k = ackQ.pop_front();
          chk("ack_kind_wr", 32'(wr_ack), 32'(k.isW));
          if (!k.isW) chk("ack_rd_data", 32'(rd_data), 32'(k.rdata));
        end
      end
      prevValid = sdram_inputValid;
      prevErr   = timeout_err;
    end
  end

  initial begin
    #1ms;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  int   ackCount;
  bit   seen;

  initial begin
    vecs[0] = '{1'b1, 25'h0000010, 16'hBEEF, 3, 1, 16'h0000, 4};
    vecs[1] = '{1'b0, 25'h0001234, 16'h0000, 2, 5, 16'h5A5A, 3};
    vecs[2] = '{1'b1, 25'h1FFFFFF, 16'hFFFF, 0, 1, 16'h0000, 1};
    vecs[3] = '{1'b0, 25'h0000000, 16'h0000, 0, 1, 16'h8001, 1};
    vecs[4] = '{1'b1, 25'h0AAAAAA, 16'h5555, 1, 1, 16'h0000, 2};

    reset = 1'b1; enable = 1'b1; sdram_isBusy = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    sdram_recievedCommand = 1'b0; sdram_outputValid = 1'b0; sdram_readData = '0;
    repeat (3) @(negedge clock_50Mhz);
    chkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clock_50Mhz);

    // Table of single transactions
    for (int i = 0; i < 5; i++) begin
      recvDelay = vecs[i].recvDly;
      rdLat     = vecs[i].rdLat;
      rdDataVal = vecs[i].rdVal;
      pushCmd(vecs[i].isW, vecs[i].addr, vecs[i].data, vecs[i].expWidth);
      pushAck(vecs[i].isW, vecs[i].rdVal);
      if (vecs[i].isW) begin
        wr_addr = vecs[i].addr; wr_data = vecs[i].data; wr_req = 1'b1;
      end else begin
        rd_addr = vecs[i].addr; rd_req = 1'b1;
      end
      waitAck("vec_ack");
      wr_req = 1'b0; rd_req = 1'b0;
      @(negedge clock_50Mhz);
    end

    // Contention from reset: W wins the first tie, then strict alternation
    reset = 1'b1;
    repeat (2) @(negedge clock_50Mhz);
    chkResetOutputs("reset2");
    reset = 1'b0;
    recvDelay = 1; rdLat = 2; rdDataVal = 16'h00C3;
    for (int i = 0; i < 3; i++) begin
      pushCmd(1'b1, 25'h100, 16'h1111, 2); pushAck(1'b1, 16'h0);
      pushCmd(1'b0, 25'h200, 16'h0000, 2); pushAck(1'b0, 16'h00C3);
    end
    wr_addr = 25'h100; wr_data = 16'h1111; rd_addr = 25'h200;
    wr_req = 1'b1; rd_req = 1'b1;
    ackCount = 0;
    for (int c = 0; c < 300 && ackCount < 6; c++) begin
      @(negedge clock_50Mhz);
      if (wr_ack || rd_ack) ackCount++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("contention_acks", 32'(ackCount), 6);
    @(negedge clock_50Mhz);
    chk("contention_cmdq_empty", 32'(cmdQ.size()), 0);
    chk("contention_ackq_empty", 32'(ackQ.size()), 0);

    // Busy gating: no grant while sdram_isBusy, grant one cycle after it clears
    recvDelay = 2; rdLat = 3;
    sdram_isBusy = 1'b1;
    pushCmd(1'b1, 25'h300, 16'h2222, 3); pushAck(1'b1, 16'h0);
    wr_addr = 25'h300; wr_data = 16'h2222; wr_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock_50Mhz);
      chk("busy_gate", 32'(sdram_inputValid), 0);
    end
    sdram_isBusy = 1'b0;
    @(negedge clock_50Mhz);
    chk("grant_after_busy", 32'(sdram_inputValid), 1);
    waitAck("busy_ack");
    wr_req = 1'b0;
    @(negedge clock_50Mhz);

    // Enable gating, then enable dropped mid-command
    enable = 1'b0; rdDataVal = 16'h7E7E;
    pushCmd(1'b0, 25'h400, 16'h0, 3); pushAck(1'b0, 16'h7E7E);
    rd_addr = 25'h400; rd_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_50Mhz);
      chk("enable_gate", 32'(sdram_inputValid), 0);
    end
    enable = 1'b1;
    @(negedge clock_50Mhz);
    chk("grant_after_enable", 32'(sdram_inputValid), 1);
    enable = 1'b0;
    waitAck("enable_mid_ack");
    for (int c = 0; c < 5; c++) begin
      @(negedge clock_50Mhz);
      chk("enable_hold_idle", 32'({sdram_inputValid, arb_busy}), 0);
    end
    rd_req = 1'b0; enable = 1'b1;
    @(negedge clock_50Mhz);

    // Reset while waiting for read data: no ack even when the data shows up
    recvDelay = 0; rdLat = 6; rdDataVal = 16'h9999;
    pushCmd(1'b0, 25'h500, 16'h0, 1);
    rd_addr = 25'h500; rd_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock_50Mhz);
      if (sdram_inputValid) seen = 1'b1;
    end
    chk("rst_rd_grant", 32'(seen), 1);
    @(negedge clock_50Mhz);
    chk("rst_rd_in_wait", 32'({sdram_inputValid, arb_busy}), 1);
    reset = 1'b1; rd_req = 1'b0;
    @(negedge clock_50Mhz);
    chkResetOutputs("reset_mid_read");
    reset = 1'b0;
    ackCount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_50Mhz);
      if (wr_ack || rd_ack) ackCount++;
    end
    chk("no_ack_after_reset", 32'(ackCount), 0);
    chk("rst_rd_data_kept_zero", 32'(rd_data), 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Controller never accepts: abort after 16 cycles, then the pending read runs
    ctrlOn = 1'b0; recvDelay = 1; rdLat = 2; rdDataVal = 16'h4242;
    pushCmd(1'b1, 25'h600, 16'h3333, 16);
    pushCmd(1'b0, 25'h700, 16'h0, 2); pushAck(1'b0, 16'h4242);
    wr_addr = 25'h600; wr_data = 16'h3333; wr_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock_50Mhz);
      if (sdram_inputValid) seen = 1'b1;
    end
    chk("to_grant", 32'(seen), 1);
    rd_addr = 25'h700; rd_req = 1'b1; wr_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock_50Mhz);
      if (timeout_err) seen = 1'b1;
    end
    chk("to_flag", 32'(seen), 1);
    chk("to_drop", 32'(sdram_inputValid), 0);
    ctrlOn = 1'b1;
    waitAck("to_next_ack");
    rd_req = 1'b0;
    repeat (3) @(negedge clock_50Mhz);
    chk("to_sticky", 32'(timeout_err), 1);
`else
    chk("timeout_err_off", 32'(timeout_err), 0);
`endif

    repeat (3) @(negedge clock_50Mhz);
    chk("final_cmdq_empty", 32'(cmdQ.size()), 0);
    chk("final_ackq_empty", 32'(ackQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
